// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_unit_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_WAIT = 2'd1;
    localparam state_t S_DROP = 2'd2;

    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam fetch_entry_t EMPTY_ENTRY = '{pc: 32'h0, instr: NOP};

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory read bus: single outstanding request, ack strobe.
interface fetch_unit_if;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );

endinterface

// File: rtl/fetch_unit_fifo.sv
// Instruction buffer: {pc, instr} entries, push/pop same cycle, sync flush.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush_i,
    input  logic          push_i,
    input  fetch_entry_t  data_i,
    input  logic          pop_i,
    output fetch_entry_t  data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [CW-1:0] cnt_q;
    fetch_entry_t  mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign count_o = cnt_q;

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Head reads as a NOP at address 0 whenever nothing is buffered.
    assign data_o = empty_o ? EMPTY_ENTRY : mem_q[rd_q];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= EMPTY_ENTRY;
            end
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (do_pop) begin
                rd_q <= rd_q + AW'(1);
            end
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: issues word reads at the PC, buffers results for decode,
// advances or redirects the PC.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDRESS = 32'h00000000,
    parameter int          FIFO_DEPTH   = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [31:0]  pc,
    output logic         pc_load,
    output logic [31:0]  pc_next,
    input  logic         redirect,
    input  logic [31:0]  redirect_target,
    fetch_unit_if.master mem,
    output logic         instr_valid,
    input  logic         instr_ready,
    output logic [31:0]  instr,
    output logic [31:0]  instr_pc
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_t        state_q;
    state_t        state_d;
    logic          req_q;
    logic          req_d;
    logic [31:0]   addr_q;
    logic [31:0]   addr_d;
    logic          load;
    logic [31:0]   nxt;
    logic          flush;
    logic          push;
    logic          pop;
    logic          space;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_cnt;
    logic [CW-1:0] occ_next;
    fetch_entry_t  head;

    assign pop  = ~fifo_empty & instr_ready;
    assign push = (state_q == S_WAIT) & mem.mem_ack & ~redirect;

    // A full buffer with no pop never has room, whatever else happens.
    assign occ_next = fifo_cnt + CW'(push) - CW'(pop);
    assign space    = ~(fifo_full & ~pop) & (occ_next < CW'(FIFO_DEPTH));

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        load    = 1'b0;
        nxt     = addr_q + 32'd4;
        flush   = 1'b0;
        if (redirect) begin
            load  = 1'b1;
            nxt   = word_align(redirect_target);
            flush = 1'b1;
            if ((state_q == S_IDLE) || mem.mem_ack) begin
                req_d   = 1'b0;
                state_d = S_IDLE;
            end else begin
                // The bus forbids withdrawing a pending request.
                state_d = S_DROP;
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (space) begin
                        req_d   = 1'b1;
                        addr_d  = pc;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem.mem_ack) begin
                        load = 1'b1;
                        if (space) begin
                            addr_d = addr_q + 32'd4;
                        end else begin
                            req_d   = 1'b0;
                            state_d = S_IDLE;
                        end
                    end
                end
                S_DROP: begin
                    if (mem.mem_ack) begin
                        req_d   = 1'b0;
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            addr_q  <= BOOT_ADDRESS;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush_i (flush),
        .push_i  (push),
        .data_i  ('{pc: addr_q, instr: mem.mem_rdata}),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign mem.mem_req  = req_q;
    assign mem.mem_addr = addr_q;

    assign pc_load     = load & reset_n;
    assign pc_next     = nxt;
    assign instr_valid = ~fifo_empty;
    assign instr       = head.instr;
    assign instr_pc    = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit with a PC register and latency memory.
module tb_fetch_unit;

    localparam logic [31:0] KEY = 32'hA5000000;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] pc;
    logic        pc_load;
    logic [31:0] pc_next;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    int          lat = 0;
    int          wcnt = 0;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] exp_q [$];

    fetch_unit_if bus ();

    fetch_unit #(
        .BOOT_ADDRESS (32'h0),
        .FIFO_DEPTH   (2)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .pc              (pc),
        .pc_load         (pc_load),
        .pc_next         (pc_next),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .mem             (bus),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .instr           (instr),
        .instr_pc        (instr_pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) pc <= 32'h0;
        else if (pc_load) pc <= pc_next;
    end

    // Memory acks after lat wait cycles; lat=0 acks in the request cycle.
    assign bus.mem_ack   = bus.mem_req && (wcnt == lat);
    assign bus.mem_rdata = bus.mem_addr ^ KEY;

    always @(posedge clk) begin
        if (bus.mem_req && !bus.mem_ack) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_instr: got pc %h instr %h expected none",
                         instr_pc, instr);
            end else begin
                check("instr_stream", {instr_pc, instr}, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_seq(input logic [31:0] start, input int n);
        logic [31:0] a;
        a = start;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({a, a ^ KEY});
            a = a + 32'd4;
        end
    endtask

    task automatic start_reset(input int l);
        instr_ready = 1'b0;
        redirect    = 1'b0;
        reset_n     = 1'b0;
        tick();
        tick();
        lat = l;
    endtask

    task automatic release_reset();
        reset_n = 1'b1;
    endtask

    task automatic drain(input string nm);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            tick();
            k++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_drain: got %0d left expected 0", nm, exp_q.size());
            exp_q.delete();
        end
        instr_ready = 1'b0;
    endtask

    task automatic wait_addr(input string nm, input logic [31:0] a);
        int k;
        k = 0;
        while (!(bus.mem_req && bus.mem_addr == a) && k < 100) begin
            tick();
            k++;
        end
        if (k == 100) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_wait: got no request expected addr %h", nm, a);
        end
    endtask

    initial begin
        int held;

        // Reset state, with a redirect held to prove pc_load is masked.
        reset_n         = 1'b0;
        redirect        = 1'b1;
        redirect_target = 32'h40;
        tick();
        tick();
        check("rst_mem_req", bus.mem_req, 1'b0);
        check("rst_mem_addr", bus.mem_addr, 32'h0);
        check("rst_valid", instr_valid, 1'b0);
        check("rst_instr", instr, NOP);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_pc_load", pc_load, 1'b0);
        redirect = 1'b0;

        // Zero-wait streaming.
        start_reset(0);
        expect_seq(32'h0, 8);
        instr_ready = 1'b1;
        release_reset();
        for (int k = 1; k <= 6; k++) begin
            tick();
            check("stream_pc", pc, 32'(4 * (k - 1)));
            check("stream_pc_load", pc_load, 1'b1);
        end
        drain("stream");

        // Backpressure fills the two-entry buffer.
        start_reset(0);
        release_reset();
        for (int k = 0; k < 5; k++) tick();
        check("bp_mem_req", bus.mem_req, 1'b0);
        check("bp_pc", pc, 32'h8);
        check("bp_valid", instr_valid, 1'b1);
        expect_seq(32'h0, 4);
        instr_ready = 1'b1;
        tick();
        check("bp_resume_req", bus.mem_req, 1'b1);
        check("bp_resume_addr", bus.mem_addr, 32'h8);
        drain("bp");

        // Three wait cycles per access.
        start_reset(3);
        expect_seq(32'h0, 3);
        instr_ready = 1'b1;
        release_reset();
        wait_addr("lat", 32'h4);
        held = 0;
        while (bus.mem_req && bus.mem_addr == 32'h4 && held < 20) begin
            held++;
            tick();
        end
        check("lat_addr_hold", 64'(held), 64'd4);
        drain("lat");

        // Redirect while the request to 0x8 is unacked.
        start_reset(3);
        exp_q.push_back({32'h0, 32'h0 ^ KEY});
        exp_q.push_back({32'h4, 32'h4 ^ KEY});
        expect_seq(32'h100, 2);
        instr_ready = 1'b1;
        release_reset();
        wait_addr("drop", 32'h8);
        redirect        = 1'b1;
        redirect_target = 32'h100;
        tick();
        redirect = 1'b0;
        check("drop_pc", pc, 32'h100);
        check("drop_req_held", bus.mem_req, 1'b1);
        check("drop_addr_held", bus.mem_addr, 32'h8);
        check("drop_valid", instr_valid, 1'b0);
        drain("drop");

        // Redirect in the same cycle as an ack, unaligned target.
        start_reset(0);
        expect_seq(32'h0, 4);
        expect_seq(32'h200, 2);
        instr_ready = 1'b1;
        release_reset();
        wait_addr("coinc", 32'h10);
        redirect        = 1'b1;
        redirect_target = 32'h203;
        tick();
        redirect = 1'b0;
        check("coinc_pc", pc, 32'h200);
        check("coinc_req", bus.mem_req, 1'b0);
        check("coinc_valid", instr_valid, 1'b0);
        tick();
        check("coinc_new_req", bus.mem_req, 1'b1);
        check("coinc_new_addr", bus.mem_addr, 32'h200);
        drain("coinc");

        // Reset asserted while waiting on memory.
        start_reset(3);
        release_reset();
        wait_addr("midrst", 32'h4);
        reset_n = 1'b0;
        #1;
        check("midrst_req", bus.mem_req, 1'b0);
        check("midrst_valid", instr_valid, 1'b0);
        check("midrst_addr", bus.mem_addr, 32'h0);
        tick();
        expect_seq(32'h0, 2);
        instr_ready = 1'b1;
        release_reset();
        tick();
        check("midrst_restart", {31'h0, bus.mem_req, bus.mem_addr}, {32'h1, 32'h0});
        drain("midrst");

        // Address wraps past the top of memory.
        start_reset(0);
        expect_seq(32'hFFFFFFF8, 4);
        release_reset();
        tick();
        redirect        = 1'b1;
        redirect_target = 32'hFFFFFFF8;
        instr_ready     = 1'b1;
        tick();
        redirect = 1'b0;
        check("wrap_pc", pc, 32'hFFFFFFF8);
        drain("wrap");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
